// File: rtl/cpu_div_cell.sv
// Sequential radix-2 restoring divider, signed/unsigned, quotient or remainder.
// Fixed WIDTH+1 cycle latency from the accepting edge to the one-cycle done pulse.
module cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             M_div_start,
  input  logic [WIDTH-1:0] M_div_src1,
  input  logic [WIDTH-1:0] M_div_src2,
  input  logic             M_div_signed,
  input  logic             M_div_rem,
  output logic [WIDTH-1:0] M_div_cell_result,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic             M_div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_f(v) : v;
  endfunction

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] src1_q;
  logic             rem_mode_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             zero_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             by_zero_q;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] result_d;

  // One restoring step: shift dividend MSB into the partial remainder and trial-subtract.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, dvsr_q};
    rem_d    = rem_sh_s[WIDTH-1:0];
    quo_d    = {quo_q[WIDTH-2:0], 1'b0};
    if (!diff_s[WIDTH]) begin
      rem_d = diff_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final value: zero divisor bypasses sign correction entirely.
  always_comb begin
    result_d = ONES_W;
    if (zero_q) begin
      result_d = rem_mode_q ? src1_q : ONES_W;
    end else if (rem_mode_q) begin
      result_d = r_neg_q ? neg_f(rem_q) : rem_q;
    end else begin
      result_d = q_neg_q ? neg_f(quo_q) : quo_q;
    end
  end

  // Control FSM with operand capture, iteration registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      dvsr_q     <= {WIDTH{1'b0}};
      quo_q      <= {WIDTH{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      src1_q     <= {WIDTH{1'b0}};
      rem_mode_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      by_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (M_div_start) begin
            rem_mode_q <= M_div_rem;
            src1_q     <= M_div_src1;
            quo_q      <= mag_f(M_div_src1, M_div_signed);
            dvsr_q     <= mag_f(M_div_src2, M_div_signed);
            q_neg_q    <= M_div_signed & (M_div_src1[WIDTH-1] ^ M_div_src2[WIDTH-1]);
            r_neg_q    <= M_div_signed & M_div_src1[WIDTH-1];
            zero_q     <= (M_div_src2 == {WIDTH{1'b0}});
            rem_q      <= {WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          done_q <= 1'b0;
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIX: begin
          result_q  <= result_d;
          by_zero_q <= zero_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign M_div_cell_result = result_q;
  assign M_div_busy        = busy_q;
  assign M_div_done        = done_q;
  assign M_div_by_zero     = by_zero_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Bench for cpu_div_cell: latency-countdown reference model checked every cycle,
// directed literal cases, randomized operations, start-while-busy and mid-run reset.
module tb_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        sgn = 1'b0;
  logic        remm = 1'b0;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        by_zero;

  int n_vec = 0;
  int n_err = 0;

  cpu_div_cell #(.WIDTH(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .M_div_start       (start),
    .M_div_src1        (src1),
    .M_div_src2        (src2),
    .M_div_signed      (sgn),
    .M_div_rem         (remm),
    .M_div_cell_result (result),
    .M_div_busy        (busy),
    .M_div_done        (done),
    .M_div_by_zero     (by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the division rules.
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
    logic [31:0] q;
    logic [31:0] m;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      m = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      m = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      m = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      m = a % b;
    end
    return r ? m : q;
  endfunction

  // Model: an accepted start produces done 33 edges later; busy in between.
  logic [31:0] m_result = 32'd0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_bz = 1'b0;
  logic [31:0] m_pend_res = 32'd0;
  logic        m_pend_bz = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_result = 32'd0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_bz     = 1'b0;
      m_left   = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_busy   = 1'b0;
          m_result = m_pend_res;
          m_bz     = m_pend_bz;
        end
      end else if (start) begin
        m_pend_res = ref_res(src1, src2, sgn, remm);
        m_pend_bz  = (src2 == 32'd0);
        m_left     = 33;
        m_busy     = 1'b1;
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    check("busy",    {31'd0, busy},    {31'd0, m_busy});
    check("done",    {31'd0, done},    {31'd0, m_done});
    check("by_zero", {31'd0, by_zero}, {31'd0, m_bz});
    check("result",  result,           m_result);
  end

  // Issue one operation (DUT must be idle or in its done cycle) and wait for done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic r, input logic [31:0] exp_res, input logic exp_bz,
                       input bit poke);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    src1 = a;
    src2 = b;
    sgn  = s;
    remm = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
    sgn   = 1'($urandom_range(0, 1));
    remm  = 1'($urandom_range(0, 1));
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else if (poke && cyc == 5) begin
        start = 1'b1;
        src1  = $urandom;
        src2  = $urandom_range(1, 100);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'd33);
    check("op_result", result, exp_res);
    check("op_by_zero", {31'd0, by_zero}, {31'd0, exp_bz});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        r;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0, 1'b1);
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'h1234, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h1234, 32'd0, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b0);
    do_op(32'h1234, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h1234, 32'd0, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("hold_result", result, 32'h1234);

    // Mid-run reset: outputs clear immediately, no done, clean restart.
    src1 = 32'd500;
    src2 = 32'd3;
    sgn  = 1'b0;
    remm = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_by_zero", {31'd0, by_zero}, 32'd0);
    check("rst_result",  result,           32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    do_op(32'd500, 32'd3, 1'b0, 1'b0, 32'd166, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      a = pick();
      b = pick();
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(a, b, s, r, ref_res(a, b, s, r), (b == 32'd0), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
